// File: rtl/mcc_pkg.sv
// Shared types and encodings for the multi-cycle controller: FSM state enum,
// opcode constants, ALUOp selections and trap cause codes.
package mcc_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        TRAP   = 4'd12
    } stateT;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALUOP_FUNCT = 2'd0;
    localparam logic [1:0] ALUOP_ADD   = 2'd1;
    localparam logic [1:0] ALUOP_SUB   = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // States that hold for a memory handshake and run the wait counter.
    function automatic logic isWaitState(input stateT s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mcc_output_decode.sv
// Combinational state -> datapath control decode for the multi-cycle controller.
// Only pcWrite (FETCH handshake) and xorBne (latched bne flag) look past the state.
module mcc_output_decode
    import mcc_pkg::*;
#(
    parameter int ALUOP_W = 3
) (
    input  stateT              state,
    input  logic               memReady,
    input  logic               bneSel,
    output logic               regDst,
    output logic               branch,
    output logic               xorBne,
    output logic               memToReg,
    output logic               memWrite,
    output logic               memRead,
    output logic               aluSrcA,
    output logic               regWe,
    output logic               jump,
    output logic               iorD,
    output logic               irWrite,
    output logic               pcWrite,
    output logic [1:0]         aluSrcB,
    output logic [ALUOP_W-1:0] aluOp,
    output logic               memReq
);

    logic [1:0] aluOpSel;

    always_comb begin
        regDst   = 1'b0;
        branch   = 1'b0;
        xorBne   = 1'b0;
        memToReg = 1'b0;
        memWrite = 1'b0;
        memRead  = 1'b0;
        aluSrcA  = 1'b0;
        regWe    = 1'b0;
        jump     = 1'b0;
        iorD     = 1'b0;
        irWrite  = 1'b0;
        pcWrite  = 1'b0;
        aluSrcB  = 2'b00;
        aluOpSel = ALUOP_FUNCT;
        memReq   = 1'b0;
        case (state)
            FETCH: begin
                memReq   = 1'b1;
                memRead  = 1'b1;
                irWrite  = 1'b1;
                aluSrcB  = 2'b01;
                aluOpSel = ALUOP_ADD;
                pcWrite  = memReady;
            end
            DECODE: begin
                aluSrcB  = 2'b11;
                aluOpSel = ALUOP_ADD;
            end
            MEMADR, ADDIEX: begin
                aluSrcA  = 1'b1;
                aluSrcB  = 2'b10;
                aluOpSel = ALUOP_ADD;
            end
            MEMRD: begin
                memReq  = 1'b1;
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            MEMWB: begin
                regWe    = 1'b1;
                memToReg = 1'b1;
            end
            MEMWR: begin
                memReq   = 1'b1;
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            EXEC: begin
                aluSrcA  = 1'b1;
                aluOpSel = ALUOP_FUNCT;
            end
            ALUWB: begin
                regWe  = 1'b1;
                regDst = 1'b1;
            end
            BRANCH: begin
                aluSrcA  = 1'b1;
                aluOpSel = ALUOP_SUB;
                branch   = 1'b1;
                xorBne   = bneSel;
            end
            JUMP: begin
                jump    = 1'b1;
                pcWrite = 1'b1;
            end
            ADDIWB: regWe = 1'b1;
            default: ;
        endcase
    end

    assign aluOp = ALUOP_W'(aluOpSel);

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style control FSM with memory-wait timeout and sticky trap.
// Define MCC_ADDI_EN to add the addi path (ADDIEX/ADDIWB); otherwise addi traps.
module multi_cycle_control
    import mcc_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] OpCode,
    input  logic                mem_ready,
    output logic                RegDst,
    output logic                Branch,
    output logic                XorBne,
    output logic                MemToReg,
    output logic                MemWrite,
    output logic                MemRead,
    output logic                ALUSrcA,
    output logic                RegWE,
    output logic                Jump,
    output logic                IorD,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic [1:0]          ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                mem_req,
    output logic [3:0]          state_o,
    output logic                err,
    output logic [1:0]          err_cause
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    stateT            state;
    stateT            nextState;
    logic [CNT_W-1:0] waitCnt;
    logic             errQ;
    logic [1:0]       causeQ;
    logic [1:0]       nextCause;
    logic             bneQ;
    logic             timedOut;

    function automatic logic opIs(input logic [OPCODE_W-1:0] op, input logic [5:0] code);
        return op == OPCODE_W'(code);
    endfunction

    // The cycle that would be the MEM_TIMEOUT-th consecutive stall; a ready wins it.
    assign timedOut = !mem_ready && (waitCnt == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        nextState = state;
        nextCause = causeQ;
        case (state)
            FETCH: begin
                if (mem_ready) begin
                    nextState = DECODE;
                end else if (timedOut) begin
                    nextState = TRAP;
                    nextCause = CAUSE_TIMEOUT;
                end
            end
            DECODE: begin
                if (opIs(OpCode, OP_R)) begin
                    nextState = EXEC;
                end else if (opIs(OpCode, OP_LW) || opIs(OpCode, OP_SW)) begin
                    nextState = MEMADR;
                end else if (opIs(OpCode, OP_BEQ) || opIs(OpCode, OP_BNE)) begin
                    nextState = BRANCH;
                end else if (opIs(OpCode, OP_J)) begin
                    nextState = JUMP;
`ifdef MCC_ADDI_EN
                end else if (opIs(OpCode, OP_ADDI)) begin
                    nextState = ADDIEX;
`endif
                end else begin
                    nextState = TRAP;
                    nextCause = CAUSE_ILLEGAL;
                end
            end
            MEMADR: begin
                if (opIs(OpCode, OP_LW)) begin
                    nextState = MEMRD;
                end else if (opIs(OpCode, OP_SW)) begin
                    nextState = MEMWR;
                end else begin
                    nextState = TRAP;
                    nextCause = CAUSE_ILLEGAL;
                end
            end
            MEMRD: begin
                if (mem_ready) begin
                    nextState = MEMWB;
                end else if (timedOut) begin
                    nextState = TRAP;
                    nextCause = CAUSE_TIMEOUT;
                end
            end
            MEMWR: begin
                if (mem_ready) begin
                    nextState = FETCH;
                end else if (timedOut) begin
                    nextState = TRAP;
                    nextCause = CAUSE_TIMEOUT;
                end
            end
            MEMWB, ALUWB, BRANCH, JUMP: nextState = FETCH;
            EXEC:   nextState = ALUWB;
`ifdef MCC_ADDI_EN
            ADDIEX: nextState = ADDIWB;
            ADDIWB: nextState = FETCH;
`endif
            TRAP:   nextState = TRAP;
            default: begin
                nextState = TRAP;
                nextCause = CAUSE_ILLEGAL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            waitCnt <= '0;
            errQ    <= 1'b0;
            causeQ  <= CAUSE_NONE;
            bneQ    <= 1'b0;
        end else begin
            state  <= nextState;
            causeQ <= nextCause;
            if (nextState == TRAP) begin
                errQ <= 1'b1;
            end
            if (nextState != state) begin
                waitCnt <= '0;
            end else if (isWaitState(state) && !mem_ready) begin
                waitCnt <= waitCnt + CNT_W'(1);
            end
            // Branch flavour is captured at decode so later OpCode changes cannot alter it.
            if (state == DECODE) begin
                bneQ <= opIs(OpCode, OP_BNE);
            end
        end
    end

    mcc_output_decode #(
        .ALUOP_W(ALUOP_W)
    ) uDecode (
        .state    (state),
        .memReady (mem_ready),
        .bneSel   (bneQ),
        .regDst   (RegDst),
        .branch   (Branch),
        .xorBne   (XorBne),
        .memToReg (MemToReg),
        .memWrite (MemWrite),
        .memRead  (MemRead),
        .aluSrcA  (ALUSrcA),
        .regWe    (RegWE),
        .jump     (Jump),
        .iorD     (IorD),
        .irWrite  (IRWrite),
        .pcWrite  (PCWrite),
        .aluSrcB  (ALUSrcB),
        .aluOp    (ALUOp),
        .memReq   (mem_req)
    );

    assign state_o   = state;
    assign err       = errQ;
    assign err_cause = causeQ;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: table-driven instruction flows
// plus hand sequences for stalls, timeouts, opcode changes and async reset.
module tb_multi_cycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] OpCode = 6'b000000;
    logic       mem_ready = 1'b0;
    logic       RegDst, Branch, XorBne, MemToReg, MemWrite, MemRead;
    logic       ALUSrcA, RegWE, Jump, IorD, IRWrite, PCWrite;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic       mem_req;
    logic [3:0] state_o;
    logic       err;
    logic [1:0] err_cause;

    multi_cycle_control dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .OpCode    (OpCode),
        .mem_ready (mem_ready),
        .RegDst    (RegDst),
        .Branch    (Branch),
        .XorBne    (XorBne),
        .MemToReg  (MemToReg),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ALUSrcA   (ALUSrcA),
        .RegWE     (RegWE),
        .Jump      (Jump),
        .IorD      (IorD),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .mem_req   (mem_req),
        .state_o   (state_o),
        .err       (err),
        .err_cause (err_cause)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, JMP = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000, BAD = 6'b111111, LB = 6'b100000;

    typedef struct packed {
        logic [3:0]  st;
        logic [20:0] outs;
    } expT;

    typedef struct packed {
        logic [5:0]      op;
        logic            bne;
        logic [1:0]      cause;
        logic [2:0]      n;
        logic [5:0][3:0] seq;
    } vecT;

    expT         sbQ[$];
    vecT         vecs[$];
    expT         cur;
    int          nAssert = 0;
    int          nFail = 0;
    logic [20:0] actOut;

    assign actOut = {RegDst, Branch, XorBne, MemToReg, MemWrite, MemRead, ALUSrcA, RegWE,
                     Jump, IorD, IRWrite, PCWrite, ALUSrcB, ALUOp, mem_req, err, err_cause};

    // Required control word per state, written out from the state table.
    function automatic logic [20:0] expOut(input int s, input logic rdy, input logic bne,
                                           input logic [1:0] cause);
        logic rd, br, xb, m2r, mw, mr, asa, rwe, jp, iod, irw, pcw, mq, e;
        logic [1:0] asb, ec;
        logic [2:0] aop;
        {rd, br, xb, m2r, mw, mr, asa, rwe, jp, iod, irw, pcw, mq, e} = '0;
        asb = 2'b00; ec = 2'b00; aop = 3'd0;
        case (s)
            0:  begin mq = 1; mr = 1; irw = 1; asb = 2'b01; aop = 3'd1; pcw = rdy; end
            1:  begin asb = 2'b11; aop = 3'd1; end
            2:  begin asa = 1; asb = 2'b10; aop = 3'd1; end
            3:  begin mq = 1; mr = 1; iod = 1; end
            4:  begin rwe = 1; m2r = 1; end
            5:  begin mq = 1; mw = 1; iod = 1; end
            6:  begin asa = 1; aop = 3'd0; end
            7:  begin rwe = 1; rd = 1; end
            8:  begin asa = 1; aop = 3'd2; br = 1; xb = bne; end
            9:  begin jp = 1; pcw = 1; end
            10: begin asa = 1; asb = 2'b10; aop = 3'd1; end
            11: begin rwe = 1; end
            12: begin e = 1; ec = cause; end
            default: ;
        endcase
        return {rd, br, xb, m2r, mw, mr, asa, rwe, jp, iod, irw, pcw, asb, aop, mq, e, ec};
    endfunction

    task automatic cyc(input logic rst, input logic [5:0] op, input logic rdy,
                       input int st, input logic bne, input logic [1:0] cause);
        expT x;
        @(posedge clk);
        #1;
        rst_n     = rst;
        OpCode    = op;
        mem_ready = rdy;
        x.st   = 4'(st);
        x.outs = expOut(st, rdy, bne, cause);
        sbQ.push_back(x);
    endtask

    task automatic addVec(input logic [5:0] op, input logic bne, input logic [1:0] cause,
                          input int n, input int s0, input int s1, input int s2,
                          input int s3, input int s4);
        vecT v;
        v.op = op; v.bne = bne; v.cause = cause; v.n = 3'(n);
        v.seq = '0;
        v.seq[0] = 4'(s0); v.seq[1] = 4'(s1); v.seq[2] = 4'(s2);
        v.seq[3] = 4'(s3); v.seq[4] = 4'(s4);
        vecs.push_back(v);
    endtask

    always @(negedge clk) begin
        if (sbQ.size() != 0) begin
            cur = sbQ.pop_front();
            nAssert++;
            if (state_o !== cur.st) begin
                nFail++;
                $display("FAIL state @%0t: got %0d, required %0d", $time, state_o, cur.st);
            end
            nAssert++;
            if (actOut !== cur.outs) begin
                nFail++;
                $display("FAIL outputs @%0t (state %0d): got %b, required %b",
                         $time, cur.st, actOut, cur.outs);
            end
        end
    end

    initial begin
        addVec(R,   1'b0, 2'b00, 4, 0, 1, 6, 7, 0);
        addVec(LW,  1'b0, 2'b00, 5, 0, 1, 2, 3, 4);
        addVec(SW,  1'b0, 2'b00, 4, 0, 1, 2, 5, 0);
        addVec(BEQ, 1'b0, 2'b00, 3, 0, 1, 8, 0, 0);
        addVec(BNE, 1'b1, 2'b00, 3, 0, 1, 8, 0, 0);
        addVec(JMP, 1'b0, 2'b00, 3, 0, 1, 9, 0, 0);
`ifdef MCC_ADDI_EN
        addVec(ADDI, 1'b0, 2'b00, 4, 0, 1, 10, 11, 0);
`else
        addVec(ADDI, 1'b0, 2'b01, 3, 0, 1, 12, 0, 0);
`endif
        addVec(BAD, 1'b0, 2'b01, 3, 0, 1, 12, 0, 0);
        addVec(LB,  1'b0, 2'b01, 3, 0, 1, 12, 0, 0);

        // Reset held, then back-to-back instructions with zero-wait memory.
        cyc(1'b0, R, 1'b0, 0, 1'b0, 2'b00);
        foreach (vecs[k]) begin
            for (int i = 0; i < int'(vecs[k].n); i++) begin
                cyc(1'b1, vecs[k].op, 1'b1, int'(vecs[k].seq[i]), vecs[k].bne, vecs[k].cause);
            end
            if (vecs[k].seq[vecs[k].n - 1] == 4'd12) begin
                cyc(1'b1, R, 1'b1, 12, 1'b0, vecs[k].cause);
                cyc(1'b0, R, 1'b0, 0, 1'b0, 2'b00);
            end
        end

        // lw with three stalled cycles in MEMRD.
        cyc(1'b1, LW, 1'b1, 0, 1'b0, 2'b00);
        cyc(1'b1, LW, 1'b1, 1, 1'b0, 2'b00);
        cyc(1'b1, LW, 1'b1, 2, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) cyc(1'b1, LW, 1'b0, 3, 1'b0, 2'b00);
        cyc(1'b1, LW, 1'b1, 3, 1'b0, 2'b00);
        cyc(1'b1, LW, 1'b1, 4, 1'b0, 2'b00);

        // OpCode changes outside DECODE/MEMADR have no effect.
        cyc(1'b1, BNE, 1'b1, 0, 1'b0, 2'b00);
        cyc(1'b1, BNE, 1'b1, 1, 1'b0, 2'b00);
        cyc(1'b1, BEQ, 1'b1, 8, 1'b1, 2'b00);
        cyc(1'b1, R,   1'b1, 0, 1'b0, 2'b00);
        cyc(1'b1, R,   1'b1, 1, 1'b0, 2'b00);
        cyc(1'b1, LW,  1'b1, 6, 1'b0, 2'b00);
        cyc(1'b1, LW,  1'b1, 7, 1'b0, 2'b00);

        // Ready arriving on the last allowed stall cycle completes the fetch.
        for (int i = 0; i < 14; i++) cyc(1'b1, JMP, 1'b0, 0, 1'b0, 2'b00);
        cyc(1'b1, JMP, 1'b1, 0, 1'b0, 2'b00);
        cyc(1'b1, JMP, 1'b1, 1, 1'b0, 2'b00);
        cyc(1'b1, JMP, 1'b1, 9, 1'b0, 2'b00);

        // Async reset in the middle of a stalled sw.
        cyc(1'b1, SW, 1'b1, 0, 1'b0, 2'b00);
        cyc(1'b1, SW, 1'b1, 1, 1'b0, 2'b00);
        cyc(1'b1, SW, 1'b1, 2, 1'b0, 2'b00);
        cyc(1'b1, SW, 1'b0, 5, 1'b0, 2'b00);
        cyc(1'b1, SW, 1'b0, 5, 1'b0, 2'b00);
        cyc(1'b0, SW, 1'b0, 0, 1'b0, 2'b00);

        // Fetch timeout: 15 stalled cycles, then sticky TRAP until reset.
        for (int i = 0; i < 15; i++) cyc(1'b1, R, 1'b0, 0, 1'b0, 2'b00);
        cyc(1'b1, R, 1'b0, 12, 1'b0, 2'b10);
        cyc(1'b1, R, 1'b1, 12, 1'b0, 2'b10);
        cyc(1'b0, R, 1'b0, 0, 1'b0, 2'b00);

        // MEMRD timeout.
        cyc(1'b1, LW, 1'b1, 0, 1'b0, 2'b00);
        cyc(1'b1, LW, 1'b1, 1, 1'b0, 2'b00);
        cyc(1'b1, LW, 1'b1, 2, 1'b0, 2'b00);
        for (int i = 0; i < 15; i++) cyc(1'b1, LW, 1'b0, 3, 1'b0, 2'b00);
        cyc(1'b1, LW, 1'b0, 12, 1'b0, 2'b10);
        cyc(1'b0, LW, 1'b0, 0, 1'b0, 2'b00);
        cyc(1'b1, R, 1'b1, 0, 1'b0, 2'b00);

        @(negedge clk);
        #1;
        nAssert++;
        if (sbQ.size() != 0) begin
            nFail++;
            $display("FAIL scoreboard drain: %0d entries left, required 0", sbQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
